// File: rtl/nco_pkg.sv
// Shared constants for the numerically controlled oscillator: default widths
// and the number of accumulator MSBs used as the sine table address.
package nco_pkg;
   localparam int unsigned ACC_W_DEF     = 24;
   localparam int unsigned LUT_AW_DEF    = 8;
   localparam int unsigned DATA_W_DEF    = 16;
   localparam int unsigned PHASE_SLICE_W = LUT_AW_DEF;
endpackage

// File: rtl/nco_lut_ram.sv
// Sine table: one write port and one registered read port, shaped so an
// SRAM macro can drop in. Only the read register is reset, never the array.
module nco_lut_ram
   import nco_pkg::*;
#(
   parameter int unsigned AW = LUT_AW_DEF,
   parameter int unsigned DW = DATA_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          csb0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] din0,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_q [(1<<AW)];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (!csb0) begin
         mem_q[addr0] <= din0;
      end
   end

   // A read colliding with a write to the same entry returns the old data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/nco_dds.sv
// Direct digital synthesizer: phase accumulator plus offset address stage
// feeding a two-stage pipelined sine table lookup.
module nco_dds
   import nco_pkg::*;
#(
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned LUT_AW = LUT_AW_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [ACC_W-1:0]  ftw,
   input  logic              ftw_ld,
   input  logic [LUT_AW-1:0] poff,
   input  logic              phase_clr,
   input  logic              csb0,
   input  logic [LUT_AW-1:0] addr0,
   input  logic [DATA_W-1:0] din0,
   output logic [DATA_W-1:0] sine_out,
   output logic              out_valid,
   output logic              wrap
);

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  ftw_q, ftw_d;
   logic [LUT_AW-1:0] rd_addr_q, rd_addr_d;
   logic              v1_q, v1_d;
   logic              valid_q;
   logic              wrap_q, wrap_d;
   logic [ACC_W:0]    sum_ext;
   logic [LUT_AW-1:0] phase_top;

   always_comb begin
      acc_d     = acc_q;
      wrap_d    = 1'b0;
      v1_d      = en & csb0;
      rd_addr_d = rd_addr_q;
      ftw_d     = ftw_ld ? ftw : ftw_q;
      sum_ext   = {1'b0, acc_q} + {1'b0, ftw_q};
      phase_top = acc_q[ACC_W-1 -: LUT_AW];
      // A clear beats an increment and makes this cycle's sample start from phase zero.
      if (phase_clr) begin
         acc_d     = '0;
         phase_top = '0;
      end else if (v1_d) begin
         acc_d  = sum_ext[ACC_W-1:0];
         wrap_d = sum_ext[ACC_W];
      end
      if (v1_d) begin
         rd_addr_d = phase_top + poff;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q     <= '0;
         ftw_q     <= '0;
         rd_addr_q <= '0;
         v1_q      <= 1'b0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         ftw_q     <= ftw_d;
         rd_addr_q <= rd_addr_d;
         v1_q      <= v1_d;
         valid_q   <= v1_q;
         wrap_q    <= wrap_d;
      end
   end

   nco_lut_ram #(
      .AW (LUT_AW),
      .DW (DATA_W)
   ) u_lut (
      .clk     (clk),
      .rst     (rst),
      .csb0    (csb0),
      .addr0   (addr0),
      .din0    (din0),
      .rd_en   (v1_q),
      .rd_addr (rd_addr_q),
      .rd_data (sine_out)
   );

   assign out_valid = valid_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_nco_dds.sv
// Self-checking bench for nco_dds: directed scenarios plus randomized traffic
// checked against an arithmetic phase/sample model.
module tb_nco_dds;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [23:0] ftw = '0;
   logic        ftw_ld = 1'b0;
   logic [7:0]  poff = '0;
   logic        phase_clr = 1'b0;
   logic        csb0 = 1'b1;
   logic [7:0]  addr0 = '0;
   logic [15:0] din0 = '0;
   logic [15:0] sine_out;
   logic        out_valid;
   logic        wrap;

   int tests = 0;
   int fails = 0;

   // reference model state
   int          m_acc, m_ftw, m_a1;
   bit          m_v1, m_valid, m_wrap;
   logic [15:0] m_sine;
   logic [15:0] m_mem [256];

   nco_dds dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .ftw       (ftw),
      .ftw_ld    (ftw_ld),
      .poff      (poff),
      .phase_clr (phase_clr),
      .csb0      (csb0),
      .addr0     (addr0),
      .din0      (din0),
      .sine_out  (sine_out),
      .out_valid (out_valid),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_acc = 0; m_ftw = 0; m_a1 = 0;
      m_v1 = 0; m_valid = 0; m_wrap = 0; m_sine = '0;
   endtask

   // One clock edge of the oscillator in plain phase arithmetic.
   task automatic model_edge();
      int  nacc, top, s;
      bit  issue, nw;
      logic [15:0] ns;
      issue = en && csb0;
      ns = m_v1 ? m_mem[m_a1] : m_sine;
      nacc = m_acc;
      nw = 0;
      top = m_acc / 65536;
      if (phase_clr) begin
         nacc = 0;
         top = 0;
      end else if (issue) begin
         s = m_acc + m_ftw;
         nw = (s >= 32'h0100_0000);
         nacc = s % 32'h0100_0000;
      end
      m_valid = m_v1;
      m_sine = ns;
      m_wrap = nw;
      if (issue) m_a1 = (top + int'(poff)) % 256;
      m_v1 = issue;
      m_acc = nacc;
      if (ftw_ld) m_ftw = int'(ftw);
      if (!csb0) m_mem[addr0] = din0;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_edge();
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #7;
      tests++;
      if (sine_out !== 16'h0 || out_valid !== 1'b0 || wrap !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: sine=%h valid=%b wrap=%b, want 0/0/0", sine_out, out_valid, wrap);
      end
      model_reset();
      #14 rst = 1'b1;
   endtask

   task automatic test_load();
      for (int i = 0; i < 256; i++) begin
         csb0 = 1'b0; addr0 = 8'(i); din0 = 16'(i * 257);
         step();
      end
      csb0 = 1'b1;
   endtask

   task automatic test_ramp_wrap();
      int wraps = 0;
      ftw = 24'h010000; ftw_ld = 1'b1; phase_clr = 1'b1; poff = 8'h00; en = 1'b0;
      step();
      ftw_ld = 1'b0; phase_clr = 1'b0; en = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         step();
         wraps += int'(wrap);
         tests++;
         if (out_valid !== (k >= 2)) begin
            fails++;
            $display("FAIL ramp_valid edge %0d: got %b want %b", k, out_valid, (k >= 2));
         end
         if (k >= 2) begin
            tests++;
            if (sine_out !== 16'((k - 2) * 257)) begin
               fails++;
               $display("FAIL ramp_sample edge %0d: got %h want %h", k, sine_out, 16'((k - 2) * 257));
            end
         end
         tests++;
         if (wrap !== (k == 256)) begin
            fails++;
            $display("FAIL ramp_wrap edge %0d: got %b want %b", k, wrap, (k == 256));
         end
      end
      tests++;
      if (wraps != 1) begin
         fails++;
         $display("FAIL wrap_count: got %0d want 1", wraps);
      end
   endtask

   task automatic test_poff();
      logic [15:0] exp_q [$];
      en = 1'b0; phase_clr = 1'b1; poff = 8'h40;
      step();
      phase_clr = 1'b0; en = 1'b1;
      step(); step();
      tests++;
      if (sine_out !== 16'h4040 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL poff_40: sine=%h valid=%b, want 4040/1", sine_out, out_valid);
      end
      en = 1'b0; phase_clr = 1'b1; poff = 8'hFF;
      step();
      phase_clr = 1'b0; en = 1'b1;
      exp_q = '{16'hFFFF, 16'h0000, 16'h0101};
      step();
      for (int k = 0; k < 3; k++) begin
         step();
         tests++;
         if (sine_out !== exp_q[k] || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL poff_ff sample %0d: sine=%h valid=%b, want %h/1", k, sine_out, out_valid, exp_q[k]);
         end
      end
   endtask

   task automatic test_ftw_change();
      int prev, delta;
      prev = int'(sine_out) / 257;
      for (int k = 0; k < 10; k++) begin
         ftw_ld = (k == 3); ftw = 24'h020000;
         step();
         delta = (int'(sine_out) / 257 - prev + 256) % 256;
         prev = int'(sine_out) / 257;
         tests++;
         if (sine_out !== m_sine || out_valid !== m_valid || delta != ((k <= 5) ? 1 : 2)) begin
            fails++;
            $display("FAIL ftw_change step %0d: sine=%h valid=%b delta=%0d, want %h/%b delta %0d",
                     k, sine_out, out_valid, delta, m_sine, m_valid, (k <= 5) ? 1 : 2);
         end
      end
      ftw_ld = 1'b0;
   endtask

   task automatic test_freeze();
      bit exp_v [7] = '{1, 0, 0, 0, 1, 1, 1};
      for (int k = 0; k < 7; k++) begin
         csb0 = !(k < 3); addr0 = 8'(k + 7); din0 = 16'((k + 7) * 257);
         step();
         tests++;
         if (out_valid !== exp_v[k] || sine_out !== m_sine || wrap !== m_wrap) begin
            fails++;
            $display("FAIL freeze edge %0d: valid=%b sine=%h wrap=%b, want %b/%h/%b",
                     k, out_valid, sine_out, wrap, exp_v[k], m_sine, m_wrap);
         end
      end
      csb0 = 1'b1;
   endtask

   task automatic test_reset_mid();
      #3 rst = 1'b0;
      #1;
      tests++;
      if (sine_out !== 16'h0 || out_valid !== 1'b0 || wrap !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: sine=%h valid=%b wrap=%b, want 0/0/0", sine_out, out_valid, wrap);
      end
      model_reset();
      step(); step();
      rst = 1'b1; poff = 8'h33; en = 1'b1;
      step(); step();
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (sine_out !== 16'h3333 || out_valid !== 1'b1 || sine_out !== m_sine) begin
            fails++;
            $display("FAIL reset_release %0d: sine=%h valid=%b, want 3333/1", k, sine_out, out_valid);
         end
         step();
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         en        = ($urandom_range(0, 3) != 0);
         csb0      = ($urandom_range(0, 9) != 0);
         ftw_ld    = ($urandom_range(0, 9) == 0);
         ftw       = 24'($urandom);
         phase_clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 9) == 0) poff = 8'($urandom);
         addr0     = 8'($urandom);
         din0      = 16'($urandom);
         step();
         tests++;
         if (sine_out !== m_sine || out_valid !== m_valid || wrap !== m_wrap) begin
            fails++;
            $display("FAIL random cycle %0d: sine=%h valid=%b wrap=%b, want %h/%b/%b",
                     k, sine_out, out_valid, wrap, m_sine, m_valid, m_wrap);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_ramp_wrap();
      test_poff();
      test_ftw_change();
      test_freeze();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
